// File: rtl/id_stage_pipe_pkg.sv
// Shared RV32I decode definitions: opcodes, funct fields, ALU/control encodings and access widths.
package id_stage_pipe_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SLL  = 5'd3;
    localparam logic [4:0] OP_SLT  = 5'd4;
    localparam logic [4:0] OP_SLTU = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_SRL  = 5'd7;
    localparam logic [4:0] OP_SRA  = 5'd8;
    localparam logic [4:0] OP_OR   = 5'd9;
    localparam logic [4:0] OP_AND  = 5'd10;

    localparam logic [2:0] NOP_OP   = 3'd0;
    localparam logic [2:0] ARITH_OP = 3'd1;
    localparam logic [2:0] LOGIC_OP = 3'd2;
    localparam logic [2:0] SHIFT_OP = 3'd3;
    localparam logic [2:0] CMP_OP   = 3'd4;
    localparam logic [2:0] MOVE_OP  = 3'd5;

    // Branch controls reuse funct3; the two codes branches never use carry NOP and JAL.
    localparam logic [2:0] CTRL_BEQ  = 3'b000;
    localparam logic [2:0] CTRL_BNE  = 3'b001;
    localparam logic [2:0] CTRL_NOP  = 3'b010;
    localparam logic [2:0] CTRL_JAL  = 3'b011;
    localparam logic [2:0] CTRL_BLT  = 3'b100;
    localparam logic [2:0] CTRL_BGE  = 3'b101;
    localparam logic [2:0] CTRL_BLTU = 3'b110;
    localparam logic [2:0] CTRL_BGEU = 3'b111;

    localparam logic [3:0] WIDTH_NONE = 4'h0;
    localparam logic [3:0] WIDTH_LB   = 4'h1;
    localparam logic [3:0] WIDTH_LH   = 4'h2;
    localparam logic [3:0] WIDTH_LW   = 4'h4;
    localparam logic [3:0] WIDTH_LBU  = 4'h5;
    localparam logic [3:0] WIDTH_LHU  = 4'h6;
    localparam logic [3:0] WIDTH_SB   = 4'h9;
    localparam logic [3:0] WIDTH_SH   = 4'hA;
    localparam logic [3:0] WIDTH_SW   = 4'hC;

    typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_PC} op1_sel_e;
    typedef enum logic {OP2_RS2, OP2_IMM} op2_sel_e;

    // alt (inst[30]) only selects SUB for register-register ops; ADDI with a negative imm stays ADD.
    function automatic logic [4:0] alu_op_f3(input logic [2:0] f3, input logic alt, input logic is_reg);
        logic [4:0] op;
        case (f3)
            F3_ADD:  op = (alt && is_reg) ? OP_SUB : OP_ADD;
            F3_SLL:  op = OP_SLL;
            F3_SLT:  op = OP_SLT;
            F3_SLTU: op = OP_SLTU;
            F3_XOR:  op = OP_XOR;
            F3_SR:   op = alt ? OP_SRA : OP_SRL;
            F3_OR:   op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    function automatic logic [2:0] alu_sel_f3(input logic [2:0] f3);
        logic [2:0] sel;
        case (f3)
            F3_ADD:                 sel = ARITH_OP;
            F3_SLL, F3_SR:          sel = SHIFT_OP;
            F3_SLT, F3_SLTU:        sel = CMP_OP;
            default:                sel = LOGIC_OP;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/id_stage_pipe_decoder.sv
// Purely combinational RV32I decoder: instruction + pc to control fields, immediate and operand-use flags.
module id_decoder
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            use_rs1,
    output logic            use_rs2,
    output logic            rd_we,
    output op1_sel_e        op1_sel,
    output op2_sel_e        op2_sel,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      aluop,
    output logic [2:0]      alusel,
    output logic [2:0]      ctrl,
    output logic [3:0]      width,
    output logic            is_jal,
    output logic            is_jalr,
    output logic [XLEN-1:0] i_imm,
    output logic [XLEN-1:0] jmp_pc,
    output logic            illegal
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic            alt;
    logic [XLEN-1:0] s_imm;
    logic [XLEN-1:0] b_imm;
    logic [XLEN-1:0] u_imm;
    logic [XLEN-1:0] j_imm;
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] pc_plus4;

    assign opcode   = inst[6:0];
    assign f3       = inst[14:12];
    assign alt      = (inst[31:25] == F7_ALT);
    assign rs1      = inst[19:15];
    assign rs2      = inst[24:20];
    assign rd       = rd_we ? inst[11:7] : 5'd0;

    assign i_imm    = XLEN'($signed(inst[31:20]));
    assign s_imm    = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign b_imm    = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign u_imm    = XLEN'($signed({inst[31:12], 12'b0}));
    assign j_imm    = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign shamt    = XLEN'(inst[24:20]);
    assign pc_plus4 = pc + XLEN'(4);

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        rd_we   = 1'b0;
        op1_sel = OP1_ZERO;
        op2_sel = OP2_IMM;
        imm     = '0;
        aluop   = OP_NOP;
        alusel  = NOP_OP;
        ctrl    = CTRL_NOP;
        width   = WIDTH_NONE;
        is_jal  = 1'b0;
        is_jalr = 1'b0;
        jmp_pc  = '0;
        illegal = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                use_rs1 = 1'b1;
                rd_we   = 1'b1;
                op1_sel = OP1_RS1;
                imm     = (f3 == F3_SLL || f3 == F3_SR) ? shamt : i_imm;
                aluop   = alu_op_f3(f3, alt, 1'b0);
                alusel  = alu_sel_f3(f3);
            end
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                rd_we   = 1'b1;
                op1_sel = OP1_RS1;
                op2_sel = OP2_RS2;
                aluop   = alu_op_f3(f3, alt, 1'b1);
                alusel  = alu_sel_f3(f3);
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1;
                rd_we   = 1'b1;
                op1_sel = OP1_RS1;
                imm     = i_imm;
                aluop   = OP_ADD;
                alusel  = ARITH_OP;
                case (f3)
                    3'b000:  width = WIDTH_LB;
                    3'b001:  width = WIDTH_LH;
                    3'b010:  width = WIDTH_LW;
                    3'b100:  width = WIDTH_LBU;
                    3'b101:  width = WIDTH_LHU;
                    default: width = WIDTH_NONE;
                endcase
            end
            // Store data travels in op2; EX forms the address from op1 + imm.
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                op1_sel = OP1_RS1;
                op2_sel = OP2_RS2;
                imm     = s_imm;
                aluop   = OP_ADD;
                alusel  = ARITH_OP;
                case (f3)
                    3'b000:  width = WIDTH_SB;
                    3'b001:  width = WIDTH_SH;
                    3'b010:  width = WIDTH_SW;
                    default: width = WIDTH_NONE;
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                rd_we   = 1'b1;
                op1_sel = (opcode == OPC_AUIPC) ? OP1_PC : OP1_ZERO;
                imm     = u_imm;
                aluop   = OP_ADD;
                alusel  = ARITH_OP;
            end
            OPC_JAL, OPC_JALR: begin
                rd_we   = 1'b1;
                use_rs1 = (opcode == OPC_JALR);
                op1_sel = (opcode == OPC_JALR) ? OP1_RS1 : OP1_PC;
                imm     = pc_plus4;
                aluop   = OP_ADD;
                alusel  = MOVE_OP;
                ctrl    = CTRL_JAL;
                is_jal  = (opcode == OPC_JAL);
                is_jalr = (opcode == OPC_JALR);
                jmp_pc  = (opcode == OPC_JAL) ? pc + j_imm : '0;
            end
            OPC_BRANCH: begin
                // funct3 010/011 would alias the NOP/JAL control codes, so they are rejected.
                if (f3 == 3'b010 || f3 == 3'b011) begin
                    illegal = 1'b1;
                end else begin
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                    op1_sel = OP1_RS1;
                    op2_sel = OP2_RS2;
                    imm     = b_imm;
                    aluop   = (f3[2:1] == 2'b00) ? OP_SUB : (f3[1] ? OP_SLTU : OP_SLT);
                    alusel  = CMP_OP;
                    ctrl    = f3;
                    jmp_pc  = pc + b_imm;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage: operand forwarding, load-use interlock, ID/EX register and JAL/JALR redirect.
module id_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int NUM_FWD  = 2,
    parameter int RA_W     = 5,
    parameter int ALUOP_W  = 5,
    parameter int ALUSEL_W = 3,
    parameter int CTRL_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [31:0]             in_inst,
    input  logic [XLEN-1:0]         in_pred,
    output logic [RA_W-1:0]         rs1_addr,
    output logic [RA_W-1:0]         rs2_addr,
    input  logic [XLEN-1:0]         rs1_data,
    input  logic [XLEN-1:0]         rs2_data,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_pending,
    input  logic [NUM_FWD*RA_W-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_op1,
    output logic [XLEN-1:0]         out_op2,
    output logic [XLEN-1:0]         out_imm,
    output logic [RA_W-1:0]         out_rd,
    output logic                    out_rd_we,
    output logic [ALUOP_W-1:0]      out_aluop,
    output logic [ALUSEL_W-1:0]     out_alusel,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [3:0]              out_width,
    output logic [XLEN-1:0]         out_jmp_addr,
    output logic                    out_illegal,
    output logic                    redirect_valid,
    output logic [XLEN-1:0]         redirect_addr
);

    import id_stage_pipe_pkg::*;

    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [4:0]      dec_rd;
    logic            dec_use_rs1;
    logic            dec_use_rs2;
    logic            dec_rd_we;
    op1_sel_e        dec_op1_sel;
    op2_sel_e        dec_op2_sel;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_aluop;
    logic [2:0]      dec_alusel;
    logic [2:0]      dec_ctrl;
    logic [3:0]      dec_width;
    logic            dec_is_jal;
    logic            dec_is_jalr;
    logic [XLEN-1:0] dec_i_imm;
    logic [XLEN-1:0] dec_jmp_pc;
    logic            dec_illegal;

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            rs1_pend;
    logic            rs2_pend;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] target;
    logic            mispredict;
    logic            stall;
    logic            advance;
    logic            accept;

    id_decoder #(.XLEN(XLEN)) u_decoder (
        .inst    (in_inst),
        .pc      (in_pc),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .rd      (dec_rd),
        .use_rs1 (dec_use_rs1),
        .use_rs2 (dec_use_rs2),
        .rd_we   (dec_rd_we),
        .op1_sel (dec_op1_sel),
        .op2_sel (dec_op2_sel),
        .imm     (dec_imm),
        .aluop   (dec_aluop),
        .alusel  (dec_alusel),
        .ctrl    (dec_ctrl),
        .width   (dec_width),
        .is_jal  (dec_is_jal),
        .is_jalr (dec_is_jalr),
        .i_imm   (dec_i_imm),
        .jmp_pc  (dec_jmp_pc),
        .illegal (dec_illegal)
    );

    assign rs1_addr = RA_W'(dec_rs1);
    assign rs2_addr = RA_W'(dec_rs2);

    // Walk sources oldest to youngest so the lowest matching index is the one that sticks.
    always_comb begin
        rs1_val  = rs1_data;
        rs2_val  = rs2_data;
        rs1_pend = 1'b0;
        rs2_pend = 1'b0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_valid[k] && fwd_addr[k*RA_W +: RA_W] == rs1_addr) begin
                rs1_val  = fwd_data[k*XLEN +: XLEN];
                rs1_pend = fwd_pending[k];
            end
            if (fwd_valid[k] && fwd_addr[k*RA_W +: RA_W] == rs2_addr) begin
                rs2_val  = fwd_data[k*XLEN +: XLEN];
                rs2_pend = fwd_pending[k];
            end
        end
        if (rs1_addr == '0) begin
            rs1_val  = '0;
            rs1_pend = 1'b0;
        end
        if (rs2_addr == '0) begin
            rs2_val  = '0;
            rs2_pend = 1'b0;
        end
    end

    always_comb begin
        case (dec_op1_sel)
            OP1_RS1: op1 = rs1_val;
            OP1_PC:  op1 = in_pc;
            default: op1 = '0;
        endcase
        op2 = (dec_op2_sel == OP2_RS2) ? rs2_val : dec_imm;
    end

    assign target     = dec_is_jalr ? ((rs1_val + dec_i_imm) & {{(XLEN-1){1'b1}}, 1'b0}) : dec_jmp_pc;
    assign mispredict = (dec_is_jal || dec_is_jalr) && (target != in_pred);
    assign stall      = (dec_use_rs1 && rs1_pend) || (dec_use_rs2 && rs2_pend);
    assign advance    = !out_valid || out_ready;
    assign in_ready   = advance && !stall && !flush;
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_op1        <= '0;
            out_op2        <= '0;
            out_imm        <= '0;
            out_rd         <= '0;
            out_rd_we      <= 1'b0;
            out_aluop      <= '0;
            out_alusel     <= '0;
            out_ctrl       <= CTRL_W'(CTRL_NOP);
            out_width      <= '0;
            out_jmp_addr   <= '0;
            out_illegal    <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_addr  <= '0;
        end else if (flush) begin
            out_valid      <= 1'b0;
            redirect_valid <= 1'b0;
        end else begin
            redirect_valid <= accept && mispredict;
            if (accept && mispredict) begin
                redirect_addr <= target;
            end
            if (accept) begin
                out_valid    <= 1'b1;
                out_pc       <= in_pc;
                out_op1      <= op1;
                out_op2      <= op2;
                out_imm      <= dec_imm;
                out_rd       <= RA_W'(dec_rd);
                out_rd_we    <= dec_rd_we;
                out_aluop    <= ALUOP_W'(dec_aluop);
                out_alusel   <= ALUSEL_W'(dec_alusel);
                out_ctrl     <= CTRL_W'(dec_ctrl);
                out_width    <= dec_width;
                out_jmp_addr <= target;
                out_illegal  <= dec_illegal;
            end else if (advance) begin
                out_valid <= 1'b0;
                out_rd_we <= 1'b0;
                out_ctrl  <= CTRL_W'(CTRL_NOP);
            end
        end
    end

endmodule
